dmem_responder: RTL and testbench

- Data-memory-side responder for the core's DMEM port: the core drives address, write data, write enable and byte select, and this block returns read data.
- Contains a byte-enabled word RAM and an MMIO page. The page holds a cycle counter, an interval timer, a transmit FIFO with a valid/ready output, and an interrupt mask.
- Drives the 6-bit interrupt vector that the core's CP0 samples.

---
 rtl/dmem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory-side responder for the core's DMEM port. It holds a
//   byte-enabled word RAM and a 256-byte MMIO page. The page contains a
//   free-running cycle counter, an interval timer, a transmit byte FIFO
//   with a valid/ready drain port, and an interrupt mask. It also drives
//   the registered 6-bit interrupt vector sampled by the core's CP0.
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   resetn        asynchronous active-low reset
//   i_addr        byte address from the core
//   i_wdata       write data from the core
//   i_we          write strobe, acted on at the rising edge
//   i_sel         byte lane enables, bit n = byte n (little-endian)
//   o_rdata       read data, combinational from i_addr
//   i_ext_int     asynchronous external interrupt requests
//   o_int         registered interrupt vector to the core
//   o_tx_valid    transmit FIFO head is valid
//   o_tx_data     transmit FIFO head byte
//   i_tx_ready    consumer accepts the head byte this cycle
//   o_bad_access  one-cycle pulse after a write outside RAM and MMIO
module dmem_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic [3:0]  i_sel,
  output logic [31:0] o_rdata,
  input  logic [3:0]  i_ext_int,
  output logic [5:0]  o_int,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_bad_access
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_TCMP   = 8'h04;
  localparam logic [7:0] OFF_TCTRL  = 8'h08;
  localparam logic [7:0] OFF_TCNT   = 8'h0C;
  localparam logic [7:0] OFF_TXDATA = 8'h10;
  localparam logic [7:0] OFF_TXSTAT = 8'h14;
  localparam logic [7:0] OFF_MASK   = 8'h18;

  localparam logic [FW:0]   CNT_ONE = 1;
  localparam logic [FW-1:0] PTR_ONE = 1;

  logic [31:0]   mem [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [31:0]   cycle;
  logic [31:0]   tcmp;
  logic [31:0]   tcnt;
  logic          t_en;
  logic          t_reload;
  logic          pending;
  logic [5:0]    mask;
  logic [FW-1:0] rptr;
  logic [FW-1:0] wptr;
  logic [FW:0]   count;
  logic          overflow;
  logic [3:0]    ext_meta;
  logic [3:0]    ext_sync;

  logic          in_ram;
  logic          in_mmio;
  logic [7:0]    offset;
  logic [AW-1:0] word_idx;
  logic          mmio_wr;
  logic          wr_tcmp;
  logic          wr_tctrl;
  logic          wr_tcnt;
  logic          wr_txdata;
  logic          wr_txstat;
  logic          wr_mask;
  logic          t_hit;
  logic          t_set;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic [31:0]   tx_status;

  assign in_ram   = (i_addr[31:AW+2] == '0);
  assign in_mmio  = (i_addr[31:8] == MMIO_BASE[31:8]);
  assign offset   = i_addr[7:0];
  assign word_idx = i_addr[AW+1:2];

  // MMIO registers are written as whole words; any enabled lane qualifies.
  assign mmio_wr   = i_we && in_mmio && (i_sel != 4'b0000);
  assign wr_tcmp   = mmio_wr && (offset == OFF_TCMP);
  assign wr_tctrl  = mmio_wr && (offset == OFF_TCTRL);
  assign wr_tcnt   = mmio_wr && (offset == OFF_TCNT);
  assign wr_txdata = mmio_wr && (offset == OFF_TXDATA);
  assign wr_txstat = mmio_wr && (offset == OFF_TXSTAT);
  assign wr_mask   = mmio_wr && (offset == OFF_MASK);

  // A software write to TCNT suppresses the compare match for that cycle.
  assign t_hit = t_en && (tcnt == tcmp);
  assign t_set = t_hit && !wr_tcnt;

  // Count reaches FIFO_DEPTH exactly when its top bit is set.
  assign full      = count[FW];
  assign empty     = (count == '0);
  assign pop       = !empty && i_tx_ready;
  assign push_ok   = wr_txdata && (!full || pop);
  assign push_drop = wr_txdata && full && !pop;

  assign o_tx_valid = !empty;
  assign o_tx_data  = fifo_mem[rptr];

  always_comb begin
    tx_status       = '0;
    tx_status[0]    = full;
    tx_status[1]    = empty;
    tx_status[2]    = overflow;
    tx_status[7+:5] = 5'(count);
  end

  always_comb begin
    o_rdata = '0;
    if (in_ram) begin
      o_rdata = mem[word_idx];
    end else if (in_mmio) begin
      case (offset)
        OFF_CYCLE:  o_rdata = cycle;
        OFF_TCMP:   o_rdata = tcmp;
        OFF_TCTRL:  o_rdata = {29'b0, pending, t_reload, t_en};
        OFF_TCNT:   o_rdata = tcnt;
        OFF_TXSTAT: o_rdata = tx_status;
        OFF_MASK:   o_rdata = {26'b0, mask};
        default:    o_rdata = '0;
      endcase
    end
  end

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (i_we && in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (i_sel[b]) mem[word_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // FIFO storage needs no reset: the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr] <= i_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle        <= '0;
      tcmp         <= 32'hFFFF_FFFF;
      tcnt         <= '0;
      t_en         <= 1'b0;
      t_reload     <= 1'b0;
      pending      <= 1'b0;
      mask         <= '0;
      rptr         <= '0;
      wptr         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      ext_meta     <= '0;
      ext_sync     <= '0;
      o_int        <= '0;
      o_bad_access <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;

      if (wr_tcmp) tcmp <= i_wdata;
      if (wr_mask) mask <= i_wdata[5:0];
      if (wr_tctrl) begin
        t_en     <= i_wdata[0];
        t_reload <= i_wdata[1];
      end

      if (wr_tcnt) begin
        tcnt <= i_wdata;
      end else if (t_en) begin
        tcnt <= (t_hit && t_reload) ? 32'd0 : tcnt + 32'd1;
      end

      // Hardware set beats a same-cycle write-one-to-clear.
      if (t_set) begin
        pending <= 1'b1;
      end else if (wr_tctrl && i_wdata[2]) begin
        pending <= 1'b0;
      end

      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (push_drop) begin
        overflow <= 1'b1;
      end else if (wr_txstat && i_wdata[2]) begin
        overflow <= 1'b0;
      end

      ext_meta <= i_ext_int;
      ext_sync <= ext_meta;

      o_int        <= {ext_sync & mask[5:2], empty & mask[1], pending & mask[0]};
      o_bad_access <= i_we && !in_ram && !in_mmio;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. Stimulus pushes expected output
//   values into a scoreboard queue; a monitor running on the falling edge
//   pops and compares them, and separately checks every byte drained from
//   the transmit port against a queue of expected FIFO bytes.
module tb_dmem_responder;

  localparam logic [31:0] BASE    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE = BASE + 32'h00;
  localparam logic [31:0] A_TCMP  = BASE + 32'h04;
  localparam logic [31:0] A_TCTRL = BASE + 32'h08;
  localparam logic [31:0] A_TCNT  = BASE + 32'h0C;
  localparam logic [31:0] A_TXD   = BASE + 32'h10;
  localparam logic [31:0] A_STAT  = BASE + 32'h14;
  localparam logic [31:0] A_MASK  = BASE + 32'h18;

  typedef enum int {K_RDATA, K_INT, K_BAD, K_VALID, K_HEAD, K_CYCLE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] value;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_we = 1'b0;
  logic [3:0]  i_sel = '0;
  logic [31:0] o_rdata;
  logic [3:0]  i_ext_int = '0;
  logic [5:0]  o_int;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b0;
  logic        o_bad_access;

  exp_t        expQ[$];
  logic [7:0]  txExp[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] tbCycles = '0;
  exp_t        monExp;
  logic [31:0] monAct;
  logic [7:0]  monByte;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  dmem_responder dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_we        (i_we),
    .i_sel       (i_sel),
    .o_rdata     (o_rdata),
    .i_ext_int   (i_ext_int),
    .o_int       (o_int),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready),
    .o_bad_access(o_bad_access)
  );

  // Reference cycle count: rising edges seen since reset was released.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) tbCycles <= '0;
    else         tbCycles <= tbCycles + 32'd1;
  end

  // Monitor: compare every queued expectation mid-cycle, and check each
  // byte the consumer accepts against the expected transmit order.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      case (monExp.kind)
        K_RDATA: monAct = o_rdata;
        K_INT:   monAct = {26'b0, o_int};
        K_BAD:   monAct = {31'b0, o_bad_access};
        K_VALID: monAct = {31'b0, o_tx_valid};
        K_HEAD:  monAct = {24'b0, o_tx_data};
        K_CYCLE: begin
          monAct       = o_rdata;
          monExp.value = tbCycles;
        end
        default: monAct = 'x;
      endcase
      vectors++;
      if (monAct !== monExp.value) begin
        miscompares++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", monExp.name, monAct, monExp.value);
      end
    end
    if (resetn && o_tx_valid && i_tx_ready) begin
      vectors++;
      if (txExp.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL tx_extra: got byte 0x%02h, expected no byte", o_tx_data);
      end else begin
        monByte = txExp.pop_front();
        if (o_tx_data !== monByte) begin
          miscompares++;
          $display("[TB] FAIL tx_order: got 0x%02h, expected 0x%02h", o_tx_data, monByte);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input kind_t k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.name  = n;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    i_addr  = a;
    i_wdata = d;
    i_sel   = s;
    i_we    = 1'b1;
    tick();
    i_we    = 1'b0;
  endtask

  task automatic readCheck(input logic [31:0] a, input logic [31:0] v, input string n);
    i_addr = a;
    i_we   = 1'b0;
    checkOutput(K_RDATA, v, n);
    tick();
  endtask

  // One-cycle pulse on the external inputs; the masked bits should appear
  // on o_int exactly three edges after the pulse is driven.
  task automatic pulseExt(input logic [3:0] v, input logic [5:0] peak, input string n);
    i_ext_int = v;
    for (int k = 0; k < 5; k++) begin
      checkOutput(K_INT, (k == 3) ? {26'b0, peak} : 32'd0, n);
      tick();
      if (k == 0) i_ext_int = 4'b0000;
    end
  endtask

  logic [31:0] tcntSeq [9] = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
  logic [31:0] intSeq  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    checkOutput(K_INT, 0, "reset_int");
    checkOutput(K_VALID, 0, "reset_tx_valid");
    checkOutput(K_BAD, 0, "reset_bad");
    readCheck(A_TCTRL, 32'h0, "reset_tctrl");
    readCheck(A_TCMP, 32'hFFFF_FFFF, "reset_tcmp");
    readCheck(A_STAT, 32'h2, "reset_txstat");
    readCheck(A_TCNT, 32'h0, "reset_tcnt");
    readCheck(A_MASK, 32'h0, "reset_mask");
    readCheck(A_TXD, 32'h0, "txdata_reads_zero");
    readCheck(BASE + 32'h1C, 32'h0, "unmapped_zero");
    i_addr = A_CYCLE;
    checkOutput(K_CYCLE, 0, "cycle_count");
    tick();

    // RAM byte lanes, boundaries and out-of-region writes
    applyStimulus(32'h0, 32'h0102_0304, 4'hF);
    applyStimulus(32'h10, 32'h1122_3344, 4'hF);
    applyStimulus(32'h10, 32'hAABB_CCDD, 4'h5);
    applyStimulus(32'h14, 32'hCAFE_F00D, 4'hF);
    applyStimulus(32'h10, 32'hFFFF_FFFF, 4'h0);
    i_sel = 4'h2;
    readCheck(32'h10, 32'h11BB_33DD, "ram_byte_lanes");
    readCheck(32'h14, 32'hCAFE_F00D, "ram_second_word");
    applyStimulus(32'hFFC, 32'h5A5A_0001, 4'hF);
    readCheck(32'hFFC, 32'h5A5A_0001, "ram_top_word");
    applyStimulus(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    checkOutput(K_BAD, 1, "bad_pulse");
    readCheck(32'h8000_0000, 32'h0, "bad_region_reads_zero");
    checkOutput(K_BAD, 0, "bad_one_cycle");
    tick();
    applyStimulus(32'h1000, 32'hFFFF_FFFF, 4'hF);
    checkOutput(K_BAD, 1, "bad_above_ram");
    readCheck(32'h0, 32'h0102_0304, "ram_no_alias");
    applyStimulus(A_MASK, 32'h3F, 4'h0);
    checkOutput(K_BAD, 0, "mmio_write_not_bad");
    readCheck(A_MASK, 32'h0, "mmio_sel0_ignored");
    applyStimulus(A_TCMP, 32'h1234_5678, 4'h1);
    readCheck(A_TCMP, 32'h1234_5678, "mmio_full_word");

    // Timer with auto-reload
    applyStimulus(A_TCMP, 32'd5, 4'hF);
    applyStimulus(A_MASK, 32'h1, 4'hF);
    applyStimulus(A_TCTRL, 32'h3, 4'hF);
    i_addr = A_TCNT;
    for (int k = 0; k < 9; k++) begin
      checkOutput(K_RDATA, tcntSeq[k], "tcnt_reload_seq");
      checkOutput(K_INT, intSeq[k], "int_timer");
      tick();
    end
    readCheck(A_TCTRL, 32'h7, "pending_set");
    applyStimulus(A_TCNT, 32'd0, 4'hF);
    applyStimulus(A_TCTRL, 32'h7, 4'hF);
    readCheck(A_TCTRL, 32'h3, "pending_w1c");
    applyStimulus(A_TCNT, 32'd4, 4'hF);
    tick();
    applyStimulus(A_TCTRL, 32'h7, 4'hF);
    readCheck(A_TCTRL, 32'h7, "pending_set_wins");
    readCheck(A_TCNT, 32'd1, "tcnt_after_reload");
    applyStimulus(A_TCTRL, 32'h7, 4'hF);
    applyStimulus(A_TCNT, 32'd4, 4'hF);
    tick();
    applyStimulus(A_TCNT, 32'd100, 4'hF);
    readCheck(A_TCNT, 32'd100, "tcnt_write_priority");
    readCheck(A_TCTRL, 32'h3, "no_set_when_written");

    // Timer without auto-reload, then disabled
    applyStimulus(A_TCTRL, 32'h1, 4'hF);
    applyStimulus(A_TCNT, 32'd4, 4'hF);
    tick();
    tick();
    readCheck(A_TCNT, 32'd6, "tcnt_no_reload");
    readCheck(A_TCTRL, 32'h5, "pending_no_reload");
    applyStimulus(A_TCTRL, 32'h4, 4'hF);
    readCheck(A_TCTRL, 32'h0, "timer_disabled");
    readCheck(A_TCNT, 32'd9, "timer_stopped");
    i_addr = A_CYCLE;
    checkOutput(K_CYCLE, 0, "cycle_count_later");
    tick();

    // Transmit FIFO: fill, overflow, push+pop while full, drain
    applyStimulus(A_MASK, 32'h2, 4'hF);
    tick();
    i_addr = A_STAT;
    checkOutput(K_INT, 32'h2, "int_fifo_empty");
    checkOutput(K_RDATA, 32'h2, "stat_empty");
    tick();
    i_tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(A_TXD, 32'hFFFF_FF00 | k, 4'hF);
      if (k <= 8) txExp.push_back(8'(k));
      if (k == 3) readCheck(A_STAT, 32'h180, "stat_count3");
    end
    checkOutput(K_VALID, 1, "tx_valid_full");
    checkOutput(K_HEAD, 32'h01, "head_first");
    checkOutput(K_INT, 0, "int_not_empty");
    readCheck(A_STAT, 32'h405, "stat_full_overflow");
    txExp.push_back(8'h55);
    i_tx_ready = 1'b1;
    applyStimulus(A_TXD, 32'h55, 4'hF);
    i_tx_ready = 1'b0;
    checkOutput(K_HEAD, 32'h02, "head_after_pushpop");
    readCheck(A_STAT, 32'h405, "stat_pushpop_full");
    i_tx_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (txExp.size() > 0 && n < 30) begin
        tick();
        n++;
      end
      if (txExp.size() > 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL drain_timeout: got %0d bytes left, expected 0", txExp.size());
      end
    end
    checkOutput(K_VALID, 0, "drained_empty");
    readCheck(A_STAT, 32'h6, "stat_empty_overflow");
    applyStimulus(A_STAT, 32'h4, 4'hF);
    checkOutput(K_INT, 32'h2, "int_empty_again");
    readCheck(A_STAT, 32'h2, "overflow_w1c");

    // Reset in the middle of activity
    i_tx_ready = 1'b0;
    applyStimulus(A_TXD, 32'hA1, 4'hF);
    applyStimulus(A_TXD, 32'hA2, 4'hF);
    applyStimulus(A_TXD, 32'hA3, 4'hF);
    applyStimulus(A_TCNT, 32'd77, 4'hF);
    applyStimulus(A_TCTRL, 32'h3, 4'hF);
    readCheck(A_STAT, 32'h180, "stat_before_reset");
    #2 resetn = 1'b0;
    txExp.delete();
    checkOutput(K_VALID, 0, "reset_flush_valid");
    checkOutput(K_INT, 0, "reset_flush_int");
    readCheck(A_STAT, 32'h2, "reset_flush_stat");
    readCheck(A_TCTRL, 32'h0, "reset_timer_ctrl");
    resetn = 1'b1;
    readCheck(A_TCNT, 32'h0, "reset_timer_count");
    readCheck(32'h10, 32'h11BB_33DD, "ram_survives_reset");

    // External interrupt synchronisers and masking
    applyStimulus(A_MASK, 32'h3C, 4'hF);
    pulseExt(4'b0100, 6'h10, "ext_int2_latency");
    pulseExt(4'b1001, 6'h24, "ext_int_bits");
    applyStimulus(A_MASK, 32'h0, 4'hF);
    pulseExt(4'b0100, 6'h00, "ext_int_masked");

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
